mdu_iter: RTL and testbench
===========================

MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameter WIDTH, default 32, sets operand width; legal values are even and >= 4.
REQ-002 Parameter FAST_MUL, default 0; when 1, multiplies use a single-cycle array product instead of iteration.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, asynchronous active-low reset (0 = reset).
REQ-005 Port start, input, 1, operation request, sampled on the rising edge.
REQ-006 Port op, input, 2, operation select: 00 mult, 01 multu, 10 div, 11 divu.
REQ-007 Port a, input, WIDTH, multiplicand or dividend, captured when start is accepted.
REQ-008 Port b, input, WIDTH, multiplier or divisor, captured when start is accepted.
REQ-009 Port cancel, input, 1, pipeline flush or exception; aborts any operation in flight.
REQ-010 Port busy, output, 1, high while an operation is in flight.
REQ-011 Port done, output, 1, one-cycle pulse; hi, lo and div_by_zero are valid in that cycle.
REQ-012 Port hi, output, WIDTH, product upper half or remainder.
REQ-013 Port lo, output, WIDTH, product lower half or quotient.
REQ-014 Port div_by_zero, output, 1, set together with done when a div or divu had b == 0.

Function
REQ-015 The state machine SHALL have the states IDLE, MUL, DIV, FIX and DONE.
REQ-016 start SHALL be accepted only in IDLE or DONE; start in MUL, DIV or FIX SHALL be ignored.
REQ-017 On acceptance, a, b and op SHALL be registered, operand magnitudes formed (signed ops), and the next state set: MUL for mult/multu, DIV for div/divu, FIX when FAST_MUL=1 and op is a multiply.
REQ-018 MUL: one shift-add step per cycle for WIDTH cycles, counter loaded with WIDTH, then FIX.
REQ-019 DIV: one restoring shift-subtract step per cycle for WIDTH cycles, then FIX.
REQ-020 FIX (1 cycle): apply sign correction, write hi/lo, go to DONE.
REQ-021 Signed multiply: the 2*WIDTH product SHALL be negated when a and b have different signs.
REQ-022 Signed divide: quotient negative iff operand signs differ; remainder takes the sign of the dividend.
REQ-023 div 0x80..0 / all-ones SHALL yield lo = 0x80..0 and hi = 0.
REQ-024 b == 0 on div/divu: lo = all-ones, hi = original a, div_by_zero = 1, normal latency.
REQ-025 Latency: done SHALL be high in the cycle after edge k+WIDTH+1 when start is sampled at edge k; for FAST_MUL multiplies, after edge k+1.
REQ-026 busy SHALL be 1 exactly in MUL, DIV and FIX; done SHALL be 1 exactly in DONE.
REQ-027 hi, lo and div_by_zero SHALL hold their last values until the next FIX; div_by_zero is cleared in FIX for non-divide ops.
REQ-028 cancel SHALL force IDLE at the next edge from any state, with no done and no hi/lo update.
REQ-029 cancel SHALL take priority over start sampled at the same edge.
REQ-030 start in DONE SHALL begin a new operation back-to-back; done is not repeated.
REQ-031 The arithmetic SHALL use a WIDTH+1-bit subtractor and a 2*WIDTH product/partial-remainder register; no extra cycles for any WIDTH.

Reset
REQ-032 rst low SHALL immediately force IDLE, busy = 0, done = 0, hi = 0, lo = 0, div_by_zero = 0, counter = 0.
REQ-033 Reset asserted mid-operation SHALL discard the operation; after release, the unit accepts start on the first edge.

Verification (WIDTH=32 unless stated)
REQ-034 multu a=0xFFFFFFFF, b=0xFFFFFFFF -> done 34 edges after start; hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 mult a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-036 divu a=7, b=0 -> lo=0xFFFFFFFF, hi=7, div_by_zero=1; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 divu 100/7, cancel at cycle 10, then multu 3*4 -> only one done pulse; hi=0, lo=12.
REQ-038 start during busy plus cancel/start same edge -> start ignored, unit IDLE; FAST_MUL=1 mult 6*-2 -> done after 2 edges, hi=0xFFFFFFFF, lo=0xFFFFFFF4.
REQ-039 WIDTH=8: divu 200/9 -> lo=22, hi=2, done 10 edges after start; rst pulse mid-DIV -> all outputs 0.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide,
// signed results by magnitude arithmetic plus a final sign-fix cycle.
module mdu_iter #(
   parameter int WIDTH    = 32,
   parameter bit FAST_MUL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               is_div_q, is_div_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic               neg_q, neg_d;
   logic               rem_neg_q, rem_neg_d;
   logic               bzero_q, bzero_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               dbz_q, dbz_d;

   logic               signed_op, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic               alu_sub;
   logic [WIDTH:0]     alu_x, alu_y, alu_res;
   logic [2*WIDTH-1:0] fix_raw, fix_prod;
   logic [WIDTH-1:0]   quo, rem;

   always_comb begin
      // NOTE: every signal assigned in this block gets a default first, so no
      // path through the case statement can leave a latch behind.
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      a_d       = a_q;
      opnd_d    = opnd_q;
      prod_d    = prod_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      bzero_d   = bzero_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      dbz_d     = dbz_q;

      signed_op = ~op[0];
      a_neg     = signed_op & a[WIDTH-1];
      b_neg     = signed_op & b[WIDTH-1];
      a_mag     = a_neg ? -a : a;
      b_mag     = b_neg ? -b : b;

      // One shared WIDTH+1-bit adder: add multiplicand in MUL, subtract divisor otherwise.
      alu_sub = (state_q != MUL);
      if (state_q == MUL) begin
         alu_x = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
         alu_y = {1'b0, opnd_q};
      end else begin
         alu_x = prod_q[2*WIDTH-1:WIDTH-1];
         alu_y = ~{1'b0, opnd_q};
      end
      alu_res = alu_x + alu_y + {{WIDTH{1'b0}}, alu_sub};

      if (FAST_MUL && !is_div_q) begin
         fix_raw = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, prod_q[WIDTH-1:0]};
      end else begin
         fix_raw = prod_q;
      end
      fix_prod = neg_q ? -fix_raw : fix_raw;
      quo      = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
      rem      = rem_neg_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               is_div_d  = op[1];
               a_d       = a;
               neg_d     = a_neg ^ b_neg;
               rem_neg_d = a_neg;
               bzero_d   = (b == '0);
               cnt_d     = CW'(WIDTH);
               if (op[1]) begin
                  opnd_d  = b_mag;
                  prod_d  = {{WIDTH{1'b0}}, a_mag};
                  state_d = DIV;
               end else begin
                  opnd_d  = a_mag;
                  prod_d  = {{WIDTH{1'b0}}, b_mag};
                  state_d = FAST_MUL ? FIX : MUL;
               end
            end
         end
         MUL: begin
            prod_d = prod_q[0] ? {alu_res, prod_q[WIDTH-1:1]}
                               : {1'b0, prod_q[2*WIDTH-1:1]};
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = FIX;
         end
         DIV: begin
            // The top adder bit is the borrow: set means the divisor did not fit.
            prod_d = alu_res[WIDTH] ? {prod_q[2*WIDTH-2:0], 1'b0}
                                    : {alu_res[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = FIX;
         end
         FIX: begin
            state_d = DONE;
            if (!is_div_q) begin
               hi_d  = fix_prod[2*WIDTH-1:WIDTH];
               lo_d  = fix_prod[WIDTH-1:0];
               dbz_d = 1'b0;
            end else if (bzero_q) begin
               hi_d  = a_q;
               lo_d  = '1;
               dbz_d = 1'b1;
            end else begin
               hi_d  = rem;
               lo_d  = quo;
               dbz_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (cancel) begin
         state_d = IDLE;
         cnt_d   = '0;
         hi_d    = hi_q;
         lo_d    = lo_q;
         dbz_d   = dbz_q;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         a_q       <= '0;
         opnd_q    <= '0;
         prod_q    <= '0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         bzero_q   <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         a_q       <= a_d;
         opnd_q    <= opnd_d;
         prod_q    <= prod_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         bzero_q   <= bzero_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         dbz_q     <= dbz_d;
      end
   end

   assign busy        = (state_q == MUL) || (state_q == DIV) || (state_q == FIX);
   assign done        = (state_q == DONE);
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: three instances (32-bit iterative, 8-bit,
// 32-bit fast multiply) checked against an arithmetic reference model.
module tb_mdu_iter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start_s  [3];
   logic [1:0]  op_s     [3];
   logic        cancel_s [3];
   logic [31:0] a_s      [3];
   logic [31:0] b_s      [3];
   logic [7:0]  a8, b8;

   logic        busy0, done0, dbz0;
   logic [31:0] hi0, lo0;
   logic        busy1, done1, dbz1;
   logic [7:0]  hi1, lo1;
   logic        busy2, done2, dbz2;
   logic [31:0] hi2, lo2;

   int n_vec, n_err;

   mdu_iter #(.WIDTH(32), .FAST_MUL(1'b0)) u_w32 (
      .clk(clk), .rst(rst), .start(start_s[0]), .op(op_s[0]), .a(a_s[0]), .b(b_s[0]),
      .cancel(cancel_s[0]), .busy(busy0), .done(done0), .hi(hi0), .lo(lo0),
      .div_by_zero(dbz0));

   mdu_iter #(.WIDTH(8), .FAST_MUL(1'b0)) u_w8 (
      .clk(clk), .rst(rst), .start(start_s[1]), .op(op_s[1]), .a(a8), .b(b8),
      .cancel(cancel_s[1]), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1),
      .div_by_zero(dbz1));

   mdu_iter #(.WIDTH(32), .FAST_MUL(1'b1)) u_fast (
      .clk(clk), .rst(rst), .start(start_s[2]), .op(op_s[2]), .a(a_s[2]), .b(b_s[2]),
      .cancel(cancel_s[2]), .busy(busy2), .done(done2), .hi(hi2), .lo(lo2),
      .div_by_zero(dbz2));

   function automatic int width_of(input int sel);
      return (sel == 1) ? 8 : 32;
   endfunction

   // Reference: plain signed/unsigned arithmetic on 64-bit integers; returns {dz, hi, lo}.
   function automatic logic [64:0] model(input int w, input logic [1:0] o,
                                         input logic [31:0] x, input logic [31:0] y);
      longint mask, sx, sy, p, q, r;
      logic [31:0] h, l;
      logic dz;
      mask = (longint'(1) << w) - 1;
      sx = longint'(x);
      sy = longint'(y);
      if (!o[0] && x[w-1]) sx = sx - (longint'(1) << w);
      if (!o[0] && y[w-1]) sy = sy - (longint'(1) << w);
      dz = 1'b0;
      if (!o[1]) begin
         p = sx * sy;
         l = 32'(p & mask);
         h = 32'((p >> w) & mask);
      end else if (y == 32'h0) begin
         l = 32'(mask);
         h = x;
         dz = 1'b1;
      end else begin
         q = sx / sy;
         r = sx % sy;
         l = 32'(q & mask);
         h = 32'(r & mask);
      end
      return {dz, h, l};
   endfunction

   task automatic sample(input int sel, output logic bsy, output logic dn,
                         output logic [31:0] h, output logic [31:0] l, output logic dz);
      case (sel)
         0: begin bsy = busy0; dn = done0; h = hi0; l = lo0; dz = dbz0; end
         1: begin bsy = busy1; dn = done1; h = {24'h0, hi1}; l = {24'h0, lo1}; dz = dbz1; end
         default: begin bsy = busy2; dn = done2; h = hi2; l = lo2; dz = dbz2; end
      endcase
   endtask

   task automatic launch(input int sel, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y);
      start_s[sel] = 1'b1;
      op_s[sel]    = o;
      if (sel == 1) begin
         a8 = x[7:0];
         b8 = y[7:0];
      end else begin
         a_s[sel] = x;
         b_s[sel] = y;
      end
   endtask

   // Counts edges from the current point until done is seen; -1 on timeout.
   task automatic wait_done(input int sel, output int lat);
      logic bsy, dn, dz;
      logic [31:0] h, l;
      lat = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk);
         #1;
         sample(sel, bsy, dn, h, l, dz);
         if (dn) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic do_op(input int sel, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, output int lat, output logic [64:0] res);
      logic bsy, dn, dz;
      logic [31:0] h, l;
      @(negedge clk);
      launch(sel, o, x, y);
      @(posedge clk);
      #1;
      start_s[sel] = 1'b0;
      wait_done(sel, lat);
      sample(sel, bsy, dn, h, l, dz);
      res = {dz, h, l};
   endtask

   task automatic test_reset();
      logic bsy, dn, dz;
      logic [31:0] h, l;
      #1;
      for (int s = 0; s < 3; s++) begin
         sample(s, bsy, dn, h, l, dz);
         n_vec++;
         if ({bsy, dn, dz, h, l} !== 67'h0) begin
            n_err++;
            $display("FAIL reset_state[%0d]: got busy=%b done=%b dz=%b hi=%h lo=%h, want all 0",
                     s, bsy, dn, dz, h, l);
         end
      end
      repeat (2) @(posedge clk);
      #1;
      sample(0, bsy, dn, h, l, dz);
      n_vec++;
      if ({bsy, dn} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_held: got busy=%b done=%b, want 0 0", bsy, dn);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [64:0] exp;
   } dvec_t;

   task automatic test_directed();
      dvec_t tbl[5];
      int lat;
      logic [64:0] res;
      tbl[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, {1'b0, 32'hFFFFFFFE, 32'h00000001}};
      tbl[1] = '{2'b00, 32'hFFFFFFFD, 32'h00000005, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1}};
      tbl[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD}};
      tbl[3] = '{2'b11, 32'h00000007, 32'h00000000, {1'b1, 32'h00000007, 32'hFFFFFFFF}};
      tbl[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, {1'b0, 32'h00000000, 32'h80000000}};
      foreach (tbl[i]) begin
         do_op(0, tbl[i].op, tbl[i].a, tbl[i].b, lat, res);
         n_vec++;
         if (lat !== 33) begin
            n_err++;
            $display("FAIL directed[%0d] latency: got %0d want 33", i, lat);
         end
         n_vec++;
         if (res !== tbl[i].exp) begin
            n_err++;
            $display("FAIL directed[%0d] result: got dz=%b hi=%h lo=%h want dz=%b hi=%h lo=%h",
                     i, res[64], res[63:32], res[31:0], tbl[i].exp[64], tbl[i].exp[63:32],
                     tbl[i].exp[31:0]);
         end
      end
   endtask

   task automatic test_fast();
      int lat;
      logic [64:0] res;
      do_op(2, 2'b00, 32'd6, 32'hFFFFFFFE, lat, res);
      n_vec++;
      if (lat !== 1) begin
         n_err++;
         $display("FAIL fast_mul latency: got %0d want 1", lat);
      end
      n_vec++;
      if (res !== {1'b0, 32'hFFFFFFFF, 32'hFFFFFFF4}) begin
         n_err++;
         $display("FAIL fast_mul result: got hi=%h lo=%h dz=%b want hi=ffffffff lo=fffffff4 dz=0",
                  res[63:32], res[31:0], res[64]);
      end
   endtask

   task automatic test_hold();
      int lat;
      logic [64:0] res;
      logic bsy, dn, dz;
      logic [31:0] h, l;
      do_op(0, 2'b11, 32'd7, 32'd0, lat, res);
      repeat (3) @(posedge clk);
      #1;
      sample(0, bsy, dn, h, l, dz);
      n_vec++;
      if ({bsy, dn, dz, h, l} !== {3'b001, 32'd7, 32'hFFFFFFFF}) begin
         n_err++;
         $display("FAIL hold_after_done: got busy=%b done=%b dz=%b hi=%h lo=%h want 0 0 1 7 ffffffff",
                  bsy, dn, dz, h, l);
      end
      do_op(0, 2'b01, 32'd2, 32'd3, lat, res);
      n_vec++;
      if (res !== {1'b0, 32'd0, 32'd6}) begin
         n_err++;
         $display("FAIL dbz_clear_on_mul: got dz=%b hi=%h lo=%h want dz=0 hi=0 lo=6",
                  res[64], res[63:32], res[31:0]);
      end
   endtask

   task automatic test_busy_start();
      int lat;
      logic bsy, dn, dz;
      logic [31:0] h, l;
      @(negedge clk);
      launch(0, 2'b00, 32'd5, 32'd7);
      @(posedge clk);
      #1;
      start_s[0] = 1'b0;
      lat = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk);
         #1;
         if (i == 5) launch(0, 2'b11, 32'd99, 32'd3);
         if (i == 6) start_s[0] = 1'b0;
         sample(0, bsy, dn, h, l, dz);
         if (dn) begin
            lat = i;
            break;
         end
      end
      n_vec++;
      if (lat !== 33 || {dz, h, l} !== {1'b0, 32'd0, 32'd35}) begin
         n_err++;
         $display("FAIL start_while_busy: got lat=%0d dz=%b hi=%h lo=%h want lat=33 dz=0 hi=0 lo=35",
                  lat, dz, h, l);
      end
      @(negedge clk);
      launch(0, 2'b00, 32'd2, 32'd2);
      cancel_s[0] = 1'b1;
      @(posedge clk);
      #1;
      start_s[0]  = 1'b0;
      cancel_s[0] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sample(0, bsy, dn, h, l, dz);
         n_vec++;
         if ({bsy, dn} !== 2'b00) begin
            n_err++;
            $display("FAIL cancel_beats_start[%0d]: got busy=%b done=%b want 0 0", i, bsy, dn);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_cancel();
      int lat, pulses;
      logic [64:0] res;
      logic bsy, dn, dz;
      logic [31:0] h0, l0, h, l;
      pulses = 0;
      sample(0, bsy, dn, h0, l0, dz);
      @(negedge clk);
      launch(0, 2'b11, 32'd100, 32'd7);
      @(posedge clk);
      #1;
      start_s[0] = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         if (i == 10) cancel_s[0] = 1'b1;
         @(posedge clk);
         #1;
         sample(0, bsy, dn, h, l, dz);
         if (dn) pulses++;
      end
      cancel_s[0] = 1'b0;
      n_vec++;
      if ({bsy, h, l} !== {1'b0, h0, l0}) begin
         n_err++;
         $display("FAIL cancel_div: got busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h",
                  bsy, h, l, h0, l0);
      end
      do_op(0, 2'b01, 32'd3, 32'd4, lat, res);
      if (lat > 0) pulses++;
      @(posedge clk);
      #1;
      sample(0, bsy, dn, h, l, dz);
      if (dn) pulses++;
      n_vec++;
      if (pulses !== 1 || res !== {1'b0, 32'd0, 32'd12}) begin
         n_err++;
         $display("FAIL cancel_then_mul: got pulses=%0d hi=%h lo=%h want pulses=1 hi=0 lo=c",
                  pulses, res[63:32], res[31:0]);
      end
      // Cancel landing in the sign-fix cycle must not touch hi/lo.
      sample(0, bsy, dn, h0, l0, dz);
      @(negedge clk);
      launch(0, 2'b01, 32'd1000, 32'd1000);
      @(posedge clk);
      #1;
      start_s[0] = 1'b0;
      repeat (32) @(posedge clk);
      #1;
      cancel_s[0] = 1'b1;
      @(posedge clk);
      #1;
      cancel_s[0] = 1'b0;
      @(posedge clk);
      #1;
      sample(0, bsy, dn, h, l, dz);
      n_vec++;
      if ({bsy, dn, h, l} !== {2'b00, h0, l0}) begin
         n_err++;
         $display("FAIL cancel_in_fix: got busy=%b done=%b hi=%h lo=%h want 0 0 %h %h",
                  bsy, dn, h, l, h0, l0);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [64:0] res, exp;
      logic bsy, dn, dz;
      logic [31:0] h, l;
      do_op(0, 2'b00, 32'd9, 32'hFFFFFFFC, lat, res);
      launch(0, 2'b11, 32'd1000, 32'd7);
      @(posedge clk);
      #1;
      start_s[0] = 1'b0;
      sample(0, bsy, dn, h, l, dz);
      n_vec++;
      if ({bsy, dn} !== 2'b10) begin
         n_err++;
         $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", bsy, dn);
      end
      wait_done(0, lat);
      sample(0, bsy, dn, h, l, dz);
      exp = model(32, 2'b11, 32'd1000, 32'd7);
      n_vec++;
      if (lat !== 33 || {dz, h, l} !== exp) begin
         n_err++;
         $display("FAIL b2b_result: got lat=%0d hi=%h lo=%h want lat=33 hi=%h lo=%h",
                  lat, h, l, exp[63:32], exp[31:0]);
      end
   endtask

   function automatic logic [31:0] rnd_opnd(input int w);
      logic [31:0] mask;
      mask = (w == 32) ? 32'hFFFFFFFF : ((32'h1 << w) - 32'h1);
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return mask;
         2: return 32'h1 << (w - 1);
         3: return 32'h1;
         default: return $urandom & mask;
      endcase
   endfunction

   task automatic test_random();
      int lat, n, w, exp_lat;
      logic [1:0] o;
      logic [31:0] x, y;
      logic [64:0] res, exp;
      for (int s = 0; s < 3; s++) begin
         n = (s == 0) ? 60 : 30;
         w = width_of(s);
         for (int i = 0; i < n; i++) begin
            o = 2'($urandom_range(0, 3));
            x = rnd_opnd(w);
            y = rnd_opnd(w);
            do_op(s, o, x, y, lat, res);
            exp = model(w, o, x, y);
            exp_lat = (s == 2 && !o[1]) ? 1 : w + 1;
            n_vec++;
            if (lat !== exp_lat || res !== exp) begin
               n_err++;
               $display("FAIL random[%0d.%0d] op=%b a=%h b=%h: got lat=%0d dz=%b hi=%h lo=%h want lat=%0d dz=%b hi=%h lo=%h",
                        s, i, o, x, y, lat, res[64], res[63:32], res[31:0], exp_lat, exp[64],
                        exp[63:32], exp[31:0]);
            end
         end
      end
   endtask

   task automatic test_w8();
      int lat;
      logic [64:0] res;
      logic bsy, dn, dz;
      logic [31:0] h, l;
      do_op(1, 2'b11, 32'd200, 32'd9, lat, res);
      n_vec++;
      if (lat !== 9 || res !== {1'b0, 32'd2, 32'd22}) begin
         n_err++;
         $display("FAIL w8_divu: got lat=%0d hi=%0d lo=%0d want lat=9 hi=2 lo=22",
                  lat, res[63:32], res[31:0]);
      end
      @(negedge clk);
      launch(1, 2'b11, 32'd200, 32'd9);
      @(posedge clk);
      #1;
      start_s[1] = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      sample(1, bsy, dn, h, l, dz);
      n_vec++;
      if ({bsy, dn, dz, h, l} !== 67'h0) begin
         n_err++;
         $display("FAIL w8_reset_mid_div: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
                  bsy, dn, dz, h, l);
      end
      @(negedge clk);
      rst = 1'b1;
      launch(1, 2'b10, 32'h000000F9, 32'd2);
      @(posedge clk);
      #1;
      start_s[1] = 1'b0;
      wait_done(1, lat);
      sample(1, bsy, dn, h, l, dz);
      n_vec++;
      if (lat !== 9 || {dz, h, l} !== model(8, 2'b10, 32'h000000F9, 32'd2)) begin
         n_err++;
         $display("FAIL w8_after_reset: got lat=%0d hi=%h lo=%h want lat=9 hi=000000ff lo=000000fd",
                  lat, h, l);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 1'b0;
      a8    = '0;
      b8    = '0;
      for (int s = 0; s < 3; s++) begin
         start_s[s]  = 1'b0;
         op_s[s]     = 2'b00;
         cancel_s[s] = 1'b0;
         a_s[s]      = '0;
         b_s[s]      = '0;
      end
      test_reset();
      test_directed();
      test_fast();
      test_hold();
      test_busy_start();
      test_cancel();
      test_back_to_back();
      test_random();
      test_w8();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
